// File: rtl/ram_commit_arbiter.sv
// rtl/ram_commit_arbiter.sv - round-robin arbiter sharing one RAM shim word-writer among NUM_REQ producers
module ram_commit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DAT_WID = 24,
    parameter int CNT_WID = 16,
    parameter int TO_WID  = 12
) (
    input  logic                       clk,
    input  logic                       rst_L,
    input  logic [NUM_REQ*DAT_WID-1:0] req_data,
    input  logic [NUM_REQ-1:0]         req_commit,
    output logic [NUM_REQ-1:0]         req_finished,
    output logic [DAT_WID-1:0]         shim_data,
    output logic                       shim_commit,
    input  logic                       shim_finished,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       busy,
    input  logic                       clear_timeout,
    output logic                       timeout,
    output logic [CNT_WID-1:0]         commit_count
);

    localparam int IDX_WID = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_ACK     = 2'd3;

    localparam logic [TO_WID-1:0] TO_MAX = '1;

    logic [1:0]         state_q, state_d;
    logic [IDX_WID-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_WID-1:0] owner_q, owner_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [DAT_WID-1:0] shim_data_q, shim_data_d;
    logic               shim_commit_q, shim_commit_d;
    logic [NUM_REQ-1:0] req_finished_q, req_finished_d;
    logic [CNT_WID-1:0] commit_count_q, commit_count_d;
    logic [TO_WID-1:0]  to_cnt_q, to_cnt_d;
    logic               timeout_q, timeout_d;

    logic               sel_valid;
    logic [IDX_WID-1:0] sel_idx;
    logic [IDX_WID-1:0] cand;
    logic [TO_WID-1:0]  to_inc;
    logic               abort;

    // Scan from the farthest offset down so the nearest pending requester after rr_ptr wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_WID'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req_commit[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        grant_d        = grant_q;
        shim_data_d    = shim_data_q;
        shim_commit_d  = shim_commit_q;
        req_finished_d = req_finished_q;
        commit_count_d = commit_count_q;
        to_cnt_d       = to_cnt_q;
        abort          = 1'b0;
        to_inc         = (to_cnt_q == TO_MAX) ? TO_MAX : to_cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    owner_d       = sel_idx;
                    grant_d       = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
                    shim_data_d   = req_data[sel_idx*DAT_WID +: DAT_WID];
                    shim_commit_d = 1'b1;
                    to_cnt_d      = '0;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                to_cnt_d = to_inc;
                if (shim_finished) begin
                    shim_commit_d  = 1'b0;
                    commit_count_d = commit_count_q + 1'b1;
                    state_d        = ST_RELEASE;
                end else if (to_inc == TO_MAX) begin
                    abort = 1'b1;
                end
            end
            ST_RELEASE: begin
                to_cnt_d = to_inc;
                if (!shim_finished) begin
                    req_finished_d = grant_q;
                    state_d        = ST_ACK;
                end else if (to_inc == TO_MAX) begin
                    abort = 1'b1;
                end
            end
            default: begin
                if (!req_commit[owner_q]) begin
                    req_finished_d = '0;
                    grant_d        = '0;
                    rr_ptr_d       = (owner_q == IDX_WID'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    state_d        = ST_IDLE;
                end
            end
        endcase

        // A stalled shim still releases the requester so it never hangs; the write is not counted.
        if (abort) begin
            shim_commit_d  = 1'b0;
            req_finished_d = grant_q;
            state_d        = ST_ACK;
        end

        if (abort)
            timeout_d = 1'b1;
        else if (clear_timeout)
            timeout_d = 1'b0;
        else
            timeout_d = timeout_q;
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            owner_q        <= '0;
            grant_q        <= '0;
            shim_data_q    <= '0;
            shim_commit_q  <= 1'b0;
            req_finished_q <= '0;
            commit_count_q <= '0;
            to_cnt_q       <= '0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            owner_q        <= owner_d;
            grant_q        <= grant_d;
            shim_data_q    <= shim_data_d;
            shim_commit_q  <= shim_commit_d;
            req_finished_q <= req_finished_d;
            commit_count_q <= commit_count_d;
            to_cnt_q       <= to_cnt_d;
            timeout_q      <= timeout_d;
        end
    end

    assign req_finished = req_finished_q;
    assign shim_data    = shim_data_q;
    assign shim_commit  = shim_commit_q;
    assign grant        = grant_q;
    assign busy         = (state_q != ST_IDLE);
    assign timeout      = timeout_q;
    assign commit_count = commit_count_q;

endmodule

// File: tb/tb_ram_commit_arbiter.sv
// tb/tb_ram_commit_arbiter.sv - self-checking bench for ram_commit_arbiter
module tb_ram_commit_arbiter;

    localparam int N      = 4;
    localparam int DW     = 24;
    localparam int CW     = 4;
    localparam int TW     = 12;
    localparam int TO_LIM = (1 << TW) - 1;

    logic            clk = 1'b0;
    logic            rst_L;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_commit;
    logic [N-1:0]    req_finished;
    logic [DW-1:0]   shim_data;
    logic            shim_commit;
    logic            shim_finished;
    logic [N-1:0]    grant;
    logic            busy;
    logic            clear_timeout;
    logic            timeout;
    logic [CW-1:0]   commit_count;

    int n_checks = 0;
    int n_fail   = 0;

    ram_commit_arbiter #(.NUM_REQ(N), .DAT_WID(DW), .CNT_WID(CW), .TO_WID(TW)) dut (
        .clk(clk), .rst_L(rst_L), .req_data(req_data), .req_commit(req_commit),
        .req_finished(req_finished), .shim_data(shim_data), .shim_commit(shim_commit),
        .shim_finished(shim_finished), .grant(grant), .busy(busy),
        .clear_timeout(clear_timeout), .timeout(timeout), .commit_count(commit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: stage 0 idle, 1 awaiting shim done, 2 awaiting shim release, 3 awaiting requester drop.
    int            m_stage, m_owner, m_ptr, m_timer, m_count;
    logic          m_timeout, m_abort;
    logic [DW-1:0] m_data;

    always @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            m_stage = 0; m_owner = -1; m_ptr = 0; m_timer = 0; m_count = 0;
            m_timeout = 1'b0; m_data = '0;
        end else begin
            m_abort = 1'b0;
            if (m_stage == 0) begin
                for (int k = 0; k < N; k++)
                    if (m_owner < 0 && req_commit[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                if (m_owner >= 0) begin
                    m_stage = 1; m_timer = 0; m_data = req_data[m_owner*DW +: DW];
                end
            end else if (m_stage == 1) begin
                m_timer++;
                if (shim_finished) begin
                    m_stage = 2; m_count = (m_count + 1) % (1 << CW);
                end else if (m_timer >= TO_LIM) m_abort = 1'b1;
            end else if (m_stage == 2) begin
                m_timer++;
                if (!shim_finished) m_stage = 3;
                else if (m_timer >= TO_LIM) m_abort = 1'b1;
            end else if (!req_commit[m_owner]) begin
                m_stage = 0; m_ptr = (m_owner + 1) % N; m_owner = -1;
            end
            if (m_abort) begin
                m_stage = 3; m_timeout = 1'b1;
            end else if (clear_timeout) m_timeout = 1'b0;
        end
    end

    logic [N-1:0] e_grant;
    always @(negedge clk) begin
        if (rst_L) begin
            e_grant = '0;
            if (m_owner >= 0) e_grant[m_owner] = 1'b1;
            check("m_grant", grant, e_grant);
            check("m_shim_commit", shim_commit, m_stage == 1);
            check("m_req_finished", req_finished, (m_stage == 3) ? e_grant : '0);
            check("m_busy", busy, m_stage != 0);
            check("m_timeout", timeout, m_timeout);
            check("m_commit_count", commit_count, m_count);
            if (m_stage != 0) check("m_shim_data", shim_data, m_data);
        end
    end

    task automatic serve(input int idx, input logic [DW-1:0] exp_data, input bit poke);
        int k;
        logic [N-1:0] eg;
        eg = 4'b0001 << idx;
        k = 0;
        while (grant == '0 && k < 50) begin @(negedge clk); k++; end
        check("grant_lit", grant, eg);
        check("shim_data_lit", shim_data, exp_data);
        if (poke) begin
            req_data[idx*DW +: DW] = ~exp_data;
            @(negedge clk);
            check("shim_data_hold", shim_data, exp_data);
        end
        shim_finished = 1'b1;
        k = 0;
        while (shim_commit && k < 50) begin @(negedge clk); k++; end
        check("commit_drop", shim_commit, 1'b0);
        check("no_early_fin", req_finished, 4'b0000);
        shim_finished = 1'b0;
        k = 0;
        while (!req_finished[idx] && k < 50) begin @(negedge clk); k++; end
        check("req_fin_lit", req_finished, eg);
        req_commit[idx] = 1'b0;
        k = 0;
        while (busy && k < 50) begin @(negedge clk); k++; end
        check("back_idle", busy, 1'b0);
    endtask

    task automatic do_reset();
        rst_L = 1'b0;
        repeat (2) @(negedge clk);
        rst_L = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_L = 1'b0; req_data = '0; req_commit = '0; shim_finished = 1'b0; clear_timeout = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_grant", grant, 4'b0000);
        check("rst_commit", shim_commit, 1'b0);
        check("rst_fin", req_finished, 4'b0000);
        check("rst_data", shim_data, 24'h000000);
        check("rst_busy", busy, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_count", commit_count, 4'd0);
        rst_L = 1'b1;
        @(negedge clk);

        // single request from requester 2
        req_data[2*DW +: DW] = 24'hABCDEF;
        req_commit[2] = 1'b1;
        serve(2, 24'hABCDEF, 1'b0);
        check("single_count", commit_count, 4'd1);

        // all four at once after reset, then 0 re-commits while 1 is pending
        do_reset();
        req_data = {24'h333333, 24'h222222, 24'h111111, 24'h000001};
        req_commit = 4'b1111;
        serve(0, 24'h000001, 1'b0);
        req_data[0 +: DW] = 24'h800000;
        req_commit[0] = 1'b1;
        serve(1, 24'h111111, 1'b0);
        serve(2, 24'h222222, 1'b0);
        serve(3, 24'h333333, 1'b0);
        serve(0, 24'h800000, 1'b1);
        check("rr_count", commit_count, 4'd5);

        // stalled shim on requester 1
        req_data[1*DW +: DW] = 24'h00BEEF;
        req_commit[1] = 1'b1;
        k = 0;
        while (grant == '0 && k < 50) begin @(negedge clk); k++; end
        check("stall_grant", grant, 4'b0010);
        k = 0;
        while (!timeout && k < 5000) begin @(negedge clk); k++; end
        check("stall_cycles", k, TO_LIM);
        check("stall_timeout", timeout, 1'b1);
        check("stall_commit", shim_commit, 1'b0);
        check("stall_fin", req_finished, 4'b0010);
        check("stall_count", commit_count, 4'd5);
        req_commit[1] = 1'b0;
        k = 0;
        while (busy && k < 50) begin @(negedge clk); k++; end
        check("stall_idle", busy, 1'b0);
        check("timeout_sticky", timeout, 1'b1);
        clear_timeout = 1'b1;
        @(negedge clk);
        clear_timeout = 1'b0;
        check("timeout_clear", timeout, 1'b0);

        // asynchronous reset mid-ISSUE with requesters 1 and 3 pending
        req_data[3*DW +: DW] = 24'h7A7A7A;
        req_data[1*DW +: DW] = 24'h0F0F0F;
        req_commit[3] = 1'b1;
        k = 0;
        while (grant == '0 && k < 50) begin @(negedge clk); k++; end
        check("pre_rst_grant", grant, 4'b1000);
        req_commit[1] = 1'b1;
        #2 rst_L = 1'b0;
        #1;
        check("arst_grant", grant, 4'b0000);
        check("arst_commit", shim_commit, 1'b0);
        check("arst_fin", req_finished, 4'b0000);
        check("arst_data", shim_data, 24'h000000);
        check("arst_busy", busy, 1'b0);
        check("arst_count", commit_count, 4'd0);
        @(negedge clk);
        rst_L = 1'b1;
        serve(1, 24'h0F0F0F, 1'b0);
        serve(3, 24'h7A7A7A, 1'b0);
        check("post_rst_count", commit_count, 4'd2);

        // counter wrap: 17 transactions since reset
        for (int i = 0; i < 15; i++) begin
            req_data[(i % N)*DW +: DW] = 24'h010101 * (i + 1);
            req_commit[i % N] = 1'b1;
            serve(i % N, 24'h010101 * (i + 1), 1'b0);
        end
        check("wrap_count", commit_count, 4'd1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_commit_arbiter.md
# ram_commit_arbiter

Round-robin arbiter that shares one RAM shim word-writer among `NUM_REQ` raster/data producers. Each requester uses the same commit/finished four-phase handshake the shim itself presents. The arbiter latches the granted requester's sample, drives the shim, and returns completion to that requester only. It also counts completed writes and flags a stalled shim with a sticky timeout.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; ≥2.
- `DAT_WID`, 24: sample width, matching the shim's data width.
- `CNT_WID`, 16: width of the completed-write counter.
- `TO_WID`, 12: timeout counter width; the timeout limit is 2^TO_WID−1 cycles.

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst_L`  in  1  asynchronous, active-low reset.
- `req_data`  in  NUM_REQ*DAT_WID  packed samples; requester i occupies `[i*DAT_WID +: DAT_WID]`; signed.
- `req_commit`  in  NUM_REQ  per-requester commit request.
- `req_finished`  out  NUM_REQ  per-requester completion.
- `shim_data`  out  DAT_WID  signed sample to the shim.
- `shim_commit`  out  1  commit to the shim.
- `shim_finished`  in  1  completion from the shim.
- `grant`  out  NUM_REQ  one-hot current owner; 0 when idle.
- `busy`  out  1  high in any state other than IDLE.
- `clear_timeout`  in  1  synchronous clear of `timeout`.
- `timeout`  out  1  sticky; set when the shim stalls.
- `commit_count`  out  CNT_WID  number of successful shim writes; wraps.

## Operation
- Reset values: all outputs 0, state IDLE, `rr_ptr` 0, timeout counter 0.
- State IDLE:
  - If any `req_commit` is high, select the first index i at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - Latch `shim_data` from slice i, set `grant[i]` and `shim_commit`, clear the timeout counter, and go to ISSUE.
- State ISSUE: wait for `shim_finished`=1.
  - On seeing it: set `shim_commit`=0, increment `commit_count`, go to RELEASE.
- State RELEASE: wait for `shim_finished`=0.
  - On seeing it: set `req_finished[i]`=1, go to ACK.
- State ACK: wait for `req_commit[i]`=0.
  - On seeing it: set `req_finished[i]`=0, clear `grant`, set `rr_ptr` to (i+1) mod NUM_REQ, go to IDLE.
- Timeout:
  - The counter increments every cycle in ISSUE and RELEASE.
  - On reaching 2^TO_WID−1: set `timeout`, drive `shim_commit`=0, set `req_finished[i]`=1, go to ACK.
  - `commit_count` is not incremented on a timeout abort. This prevents requester hang.
- `clear_timeout` clears `timeout` the next cycle. If a new timeout fires in the same cycle, set wins.
- `shim_data` is held constant from grant until return to IDLE. Changes on `req_data` during ownership are ignored.
- Non-granted requesters see `req_finished`=0 for the whole transaction. Their commits stay pending.
- Asynchronous reset mid-transaction: immediate return to reset values. `shim_commit` drops; the shim must tolerate commit deassertion.

## Timing
- Grant latency: `req_commit` high sampled at edge n gives `grant` and `shim_commit` high after edge n (registered), visible for cycle n+1.
- `shim_finished` sampled high at edge m gives `shim_commit` low and the count updated after edge m.
- `shim_finished` sampled low at edge p gives `req_finished[i]` high after edge p.
- `req_commit[i]` sampled low at edge q gives `req_finished[i]` and `grant` low, IDLE after edge q.
- The next grant is earliest at edge q+1; there is a minimum of 1 IDLE cycle between transactions.
- Best-case transaction: 4 cycles from grant to IDLE with an ideal shim and requester.
- Simultaneous requests: only one grant per transaction. Round-robin guarantees each pending requester is served within NUM_REQ transactions.
- `commit_count` wraps from 2^CNT_WID−1 to 0 without a flag.

## Test plan
- Single request: requester 2 commits `24'hABCDEF`.
  - Required: `shim_data`=`ABCDEF`, `grant`=`4'b0100`.
  - Required: `req_finished[2]` rises only after `shim_finished` falls.
  - Required: `commit_count`=1.
- All four requesters commit at the same time after reset.
  - Required grant order: 0, 1, 2, 3. Then 0 re-commits while 1 is also pending → 1 is served before 0.
- Data stability: change `req_data[0]` during ISSUE.
  - Required: `shim_data` stays at the latched value.
- Stalled shim: hold `shim_finished`=0.
  - Required: after 4095 cycles (TO_WID=12), `timeout`=1, `shim_commit`=0, `req_finished` to the owner, `commit_count` unchanged.
  - Then `clear_timeout` → `timeout`=0.
- Reset mid-ISSUE: assert `rst_L`=0.
  - Required: all outputs 0 asynchronously. After release, a pending request is granted starting from index 0.
- Counter wrap: CNT_WID=4, 17 transactions.
  - Required: `commit_count`=1.
